// File: rtl/ctrl_pkg.sv
// Shared encodings for the npc core control path: ALU function codes, MIPS
// opcode/funct constants, datapath mux selects and the control FSM state type.
package ctrl_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b1010;
    localparam logic [3:0] ALU_SLT = 4'b1011;
    localparam logic [3:0] ALU_SLL = 4'b0100;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] BSEL_RT      = 2'b00;
    localparam logic [1:0] BSEL_FOUR    = 2'b01;
    localparam logic [1:0] BSEL_IMM     = 2'b10;
    localparam logic [1:0] BSEL_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    function automatic logic opcode_known(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_BLEZ, OP_ADDI, OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_f_dec.sv
// R-type funct to ALU function code map; valid is low for any funct the
// datapath cannot execute.
module alu_f_dec
    import ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] f,
    output logic       valid
);

    always_comb begin
        f     = ALU_ADD;
        valid = 1'b1;
        case (funct)
            FN_ADD:  f = ALU_ADD;
            FN_SUB:  f = ALU_SUB;
            FN_AND:  f = ALU_AND;
            FN_OR:   f = ALU_OR;
            FN_SLT:  f = ALU_SLT;
            FN_SLL:  f = ALU_SLL;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the npc core: sequences FETCH/DECODE/EXEC/MEM/WB
// and drives ALU function, operand selects and register/PC/memory strobes.
//
// state  | meaning
// RESET  | outputs idle, leaves on first clock after reset
// FETCH  | PC+4, accept instruction word into IR
// DECODE | compute branch target into ALUOut, reject unsupported encodings
// EXEC   | ALU operation, branch/jump resolution
// MEM    | memory request, waits for mem_ready (optional timeout)
// WB     | register-file write
// HALT   | illegal instruction or bus error, left only by reset
module mc_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       alu_ltez,
    output logic [3:0] alu_f,
    output logic       alu_a_sel,
    output logic [1:0] alu_b_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       rf_we,
    output logic       rf_dst,
    output logic       rf_wsrc,
    output logic       mem_req,
    output logic       mem_we,
    input  logic       mem_ready,
    output logic       illegal,
    output logic       bus_err
);

    localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t          state_q;
    logic [5:0]      op_q;
    logic [5:0]      funct_q;
    logic            illegal_q;
    logic            bus_err_q;
    logic [CW-1:0]   wait_cnt_q;

    logic [3:0]      fn_f;
    logic            fn_valid;

    alu_f_dec u_f_dec (
        .funct (funct_q),
        .f     (fn_f),
        .valid (fn_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RESET;
            op_q       <= '0;
            funct_q    <= '0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_RESET: state_q <= ST_FETCH;
                ST_FETCH: begin
                    if (instr_valid) begin
                        op_q    <= opcode;
                        funct_q <= funct;
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (!opcode_known(op_q) || (op_q == OP_RTYPE && !fn_valid)) begin
                        illegal_q <= 1'b1;
                        state_q   <= ST_HALT;
                    end else begin
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    wait_cnt_q <= '0;
                    case (op_q)
                        OP_RTYPE, OP_ADDI: state_q <= ST_WB;
                        OP_LW, OP_SW:      state_q <= ST_MEM;
                        default:           state_q <= ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        state_q <= (op_q == OP_LW) ? ST_WB : ST_FETCH;
                    end else if ((MEM_TIMEOUT > 0) && (wait_cnt_q == TO_LAST)) begin
                        bus_err_q <= 1'b1;
                        state_q   <= ST_HALT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CW'(1);
                    end
                end
                ST_WB:   state_q <= ST_FETCH;
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_RESET;
            endcase
        end
    end

    // Strobes follow the state register; only FETCH and branch resolution look at live inputs.
    always_comb begin
        instr_ready = 1'b0;
        alu_f       = 4'b0000;
        alu_a_sel   = 1'b0;
        alu_b_sel   = 2'b00;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 2'b00;
        rf_we       = 1'b0;
        rf_dst      = 1'b0;
        rf_wsrc     = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        case (state_q)
            ST_FETCH: begin
                instr_ready = 1'b1;
                alu_b_sel   = BSEL_FOUR;
                alu_f       = ALU_ADD;
                ir_we       = instr_valid;
                pc_we       = instr_valid;
                pc_src      = PCSRC_ALU;
            end
            ST_DECODE: begin
                alu_b_sel = BSEL_IMM_SH2;
                alu_f     = ALU_ADD;
            end
            ST_EXEC: begin
                case (op_q)
                    OP_RTYPE: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = BSEL_RT;
                        alu_f     = fn_f;
                    end
                    OP_LW, OP_SW, OP_ADDI: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = BSEL_IMM;
                        alu_f     = ALU_ADD;
                    end
                    OP_BEQ, OP_BLEZ: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = BSEL_RT;
                        alu_f     = ALU_SUB;
                        pc_src    = PCSRC_ALUOUT;
                        pc_we     = (op_q == OP_BEQ) ? alu_zero : alu_ltez;
                    end
                    OP_J: begin
                        pc_we  = 1'b1;
                        pc_src = PCSRC_JUMP;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (op_q == OP_SW);
            end
            ST_WB: begin
                rf_we   = 1'b1;
                rf_dst  = (op_q == OP_RTYPE);
                rf_wsrc = (op_q == OP_LW);
            end
            default: ;
        endcase
    end

    assign illegal = illegal_q;
    assign bus_err = bus_err_q;

endmodule
